// File: rtl/matriz_pkg.sv
// Shared types and constants for the 8x8 board matrix write-port controller.
package matriz_pkg;
  localparam int DIM    = 8;
  localparam int CELL_W = 9;
  localparam int IDX_W  = 3;
  localparam int CELLS  = DIM * DIM;
  localparam int CNT_W  = 6;

  typedef logic [CELL_W-1:0] cell_t;
  typedef logic [IDX_W-1:0]  idx_t;

  localparam cell_t INIT_VAL = 9'b001000000;

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} ctrl_state_t;
  typedef enum logic {REQ_A = 1'b0, REQ_B = 1'b1} req_id_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; bit 0 is requester A, bit 1 is requester B.
module rr_arb2
  import matriz_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       enable,
  input  logic       accept,
  output logic [1:0] grant
);
  req_id_t last_q, last_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_q <= REQ_B;
    else       last_q <= last_d;
  end

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    grant = 2'b00;
    if (enable) begin
      if (req == 2'b11) grant = (last_q == REQ_B) ? 2'b01 : 2'b10;
      else              grant = req;
    end
  end

  always_comb begin
    last_d = last_q;
    if (accept) last_d = grant[0] ? REQ_A : REQ_B;
  end
endmodule

// File: rtl/matriz_ctrl.sv
// Board matrix write-port controller: post-reset / on-demand clear sweep,
// otherwise round-robin sharing of the write port between requesters A and B.
module matriz_ctrl
  import matriz_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear_req,
  input  logic       a_valid,
  input  logic [2:0] a_row,
  input  logic [2:0] a_col,
  input  logic [8:0] a_data,
  output logic       a_ready,
  input  logic       b_valid,
  input  logic [2:0] b_row,
  input  logic [2:0] b_col,
  input  logic [8:0] b_data,
  output logic       b_ready,
  output logic       wr_en,
  output logic [2:0] wr_row,
  output logic [2:0] wr_col,
  output logic [8:0] wr_data,
  output logic       busy,
  output logic       clear_done
);
  ctrl_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fin_q, fin_d;
  logic             wr_en_q, wr_en_d;
  idx_t             wr_row_q, wr_row_d;
  idx_t             wr_col_q, wr_col_d;
  cell_t            wr_data_q, wr_data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [1:0]       grant;
  logic             arb_en, acc_a, acc_b;

  rr_arb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    ({b_valid, a_valid}),
    .enable (arb_en),
    .accept (acc_a | acc_b),
    .grant  (grant)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= CLEAR;
      cnt_q     <= '0;
      fin_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_row_q  <= '0;
      wr_col_q  <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      fin_q     <= fin_d;
      wr_en_q   <= wr_en_d;
      wr_row_q  <= wr_row_d;
      wr_col_q  <= wr_col_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // fin_q marks the extra cycle after cell 63 in which clear_done is produced.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fin_d   = fin_q;
    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d = CLEAR;
          cnt_d   = CNT_W'(1);
          fin_d   = 1'b0;
        end
      end
      CLEAR: begin
        if (fin_q) begin
          state_d = IDLE;
          cnt_d   = '0;
          fin_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          fin_d = (cnt_q == CNT_W'(CELLS - 1));
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A clear requested from IDLE writes cell 0 on the same edge it is sampled.
  always_comb begin
    arb_en    = (state_q == IDLE) && !clear_req;
    a_ready   = grant[0];
    b_ready   = grant[1];
    acc_a     = a_valid && a_ready;
    acc_b     = b_valid && b_ready;
    wr_en_d   = 1'b0;
    wr_row_d  = wr_row_q;
    wr_col_d  = wr_col_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    busy_d    = (state_d == CLEAR);
    case (state_q)
      IDLE: begin
        if (clear_req) begin
          wr_en_d   = 1'b1;
          wr_row_d  = '0;
          wr_col_d  = '0;
          wr_data_d = INIT_VAL;
        end else if (acc_a) begin
          wr_en_d   = 1'b1;
          wr_row_d  = a_row;
          wr_col_d  = a_col;
          wr_data_d = a_data;
        end else if (acc_b) begin
          wr_en_d   = 1'b1;
          wr_row_d  = b_row;
          wr_col_d  = b_col;
          wr_data_d = b_data;
        end
      end
      CLEAR: begin
        if (fin_q) begin
          done_d = 1'b1;
        end else begin
          wr_en_d   = 1'b1;
          wr_row_d  = cnt_q[5:3];
          wr_col_d  = cnt_q[2:0];
          wr_data_d = INIT_VAL;
        end
      end
      default: ;
    endcase
  end

  assign wr_en      = wr_en_q;
  assign wr_row     = wr_row_q;
  assign wr_col     = wr_col_q;
  assign wr_data    = wr_data_q;
  assign busy       = busy_q;
  assign clear_done = done_q;
endmodule

// File: tb/tb_matriz_ctrl.sv
// Bench for matriz_ctrl: directed sweeps, a vector table and a randomized run
// checked against a cell-queue reference model.
module tb_matriz_ctrl;
  import matriz_pkg::*;

  logic clk = 1'b0;
  logic reset, clear_req;
  logic a_valid, b_valid, a_ready, b_ready;
  idx_t a_row, a_col, b_row, b_col;
  cell_t a_data, b_data;
  logic wr_en, busy, clear_done;
  idx_t wr_row, wr_col;
  cell_t wr_data;
  logic [17:0] out_v;

  int errors = 0;
  int checks = 0;

  logic [14:0] exp_q[$];

  typedef struct {
    logic av; idx_t ar; idx_t ac; cell_t ad;
    logic bv; idx_t br; idx_t bc; cell_t bd;
    logic [1:0] rdy; logic [17:0] out;
  } vec_t;
  vec_t vecs[8];

  logic [14:0] alt_a[2];
  logic [14:0] alt_b[2];
  logic [17:0] alt_out[4];
  logic [1:0]  alt_rdy[4];

  logic        m_sweep, m_last, ma, mb;
  logic [14:0] m_hold;
  logic [17:0] e_out;
  int          ai, bi;

  always #5 clk = ~clk;

  matriz_ctrl dut (
    .clk(clk), .reset(reset), .clear_req(clear_req),
    .a_valid(a_valid), .a_row(a_row), .a_col(a_col), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_row(b_row), .b_col(b_col), .b_data(b_data), .b_ready(b_ready),
    .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
    .busy(busy), .clear_done(clear_done)
  );

  assign out_v = {wr_en, busy, clear_done, wr_row, wr_col, wr_data};

  function automatic logic [17:0] pack(input logic en, input logic bsy, input logic dn,
                                       input idx_t r, input idx_t c, input cell_t d);
    return {en, bsy, dn, r, c, d};
  endfunction

  function automatic vec_t mk(input logic av, input idx_t ar, input idx_t ac, input cell_t ad,
                              input logic bv, input idx_t br, input idx_t bc, input cell_t bd,
                              input logic [1:0] rdy, input logic [17:0] out);
    vec_t v;
    v.av = av; v.ar = ar; v.ac = ac; v.ad = ad;
    v.bv = bv; v.br = br; v.bc = bc; v.bd = bd;
    v.rdy = rdy; v.out = out;
    return v;
  endfunction

  task automatic check_out(input string name, input logic [17:0] act, input logic [17:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: outputs {en,busy,done,row,col,data} got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_rdy(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: {a_ready,b_ready} got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Expects edge E to be the next rising edge; ends inside the clear_done cycle.
  task automatic expect_sweep(input int pulse_at);
    for (int i = 0; i < CELLS; i++) begin
      tick();
      clear_req = (i == pulse_at);
      #1;
      check_out("sweep_cell", out_v, pack(1'b1, 1'b1, 1'b0, 3'(i / 8), 3'(i % 8), INIT_VAL));
      check_rdy("sweep_rdy", {a_ready, b_ready}, 2'b00);
    end
    tick();
    clear_req = 1'b0;
    #1;
    check_out("sweep_done", out_v, pack(1'b0, 1'b0, 1'b1, 3'd7, 3'd7, INIT_VAL));
  endtask

  initial begin
    reset = 1'b1; clear_req = 1'b0;
    a_valid = 1'b0; a_row = '0; a_col = '0; a_data = '0;
    b_valid = 1'b0; b_row = '0; b_col = '0; b_data = '0;

    vecs[0] = mk(1'b1, 3'd2, 3'd5, 9'd300, 1'b0, 3'd0, 3'd0, 9'd0,   2'b10, pack(1'b1, 1'b0, 1'b0, 3'd2, 3'd5, 9'd300));
    vecs[1] = mk(1'b0, 3'd0, 3'd0, 9'd0,   1'b0, 3'd0, 3'd0, 9'd0,   2'b00, pack(1'b0, 1'b0, 1'b0, 3'd2, 3'd5, 9'd300));
    vecs[2] = mk(1'b1, 3'd1, 3'd1, 9'd11,  1'b1, 3'd6, 3'd7, 9'd400, 2'b01, pack(1'b1, 1'b0, 1'b0, 3'd6, 3'd7, 9'd400));
    vecs[3] = mk(1'b1, 3'd1, 3'd1, 9'd11,  1'b1, 3'd3, 3'd4, 9'd5,   2'b10, pack(1'b1, 1'b0, 1'b0, 3'd1, 3'd1, 9'd11));
    vecs[4] = mk(1'b0, 3'd0, 3'd0, 9'd0,   1'b1, 3'd0, 3'd7, 9'd511, 2'b01, pack(1'b1, 1'b0, 1'b0, 3'd0, 3'd7, 9'd511));
    vecs[5] = mk(1'b0, 3'd0, 3'd0, 9'd0,   1'b1, 3'd7, 3'd0, 9'd1,   2'b01, pack(1'b1, 1'b0, 1'b0, 3'd7, 3'd0, 9'd1));
    vecs[6] = mk(1'b1, 3'd4, 3'd4, 9'd100, 1'b1, 3'd5, 3'd5, 9'd200, 2'b10, pack(1'b1, 1'b0, 1'b0, 3'd4, 3'd4, 9'd100));
    vecs[7] = mk(1'b0, 3'd0, 3'd0, 9'd0,   1'b0, 3'd0, 3'd0, 9'd0,   2'b00, pack(1'b0, 1'b0, 1'b0, 3'd4, 3'd4, 9'd100));

    alt_a[0] = {3'd1, 3'd0, 9'd10}; alt_a[1] = {3'd1, 3'd1, 9'd11};
    alt_b[0] = {3'd2, 3'd0, 9'd20}; alt_b[1] = {3'd2, 3'd1, 9'd21};
    alt_rdy[0] = 2'b10; alt_rdy[1] = 2'b01; alt_rdy[2] = 2'b10; alt_rdy[3] = 2'b01;
    alt_out[0] = {3'b100, alt_a[0]}; alt_out[1] = {3'b100, alt_b[0]};
    alt_out[2] = {3'b100, alt_a[1]}; alt_out[3] = {3'b100, alt_b[1]};

    // Reset state and the post-reset sweep.
    repeat (3) @(posedge clk);
    #2;
    check_out("reset_outs", out_v, 18'd0);
    check_rdy("reset_rdy", {a_ready, b_ready}, 2'b00);
    reset = 1'b0;
    expect_sweep(-1);

    // Vector table in IDLE, starting with last grant = B.
    for (int k = 0; k < 8; k++) begin
      a_valid = vecs[k].av; a_row = vecs[k].ar; a_col = vecs[k].ac; a_data = vecs[k].ad;
      b_valid = vecs[k].bv; b_row = vecs[k].br; b_col = vecs[k].bc; b_data = vecs[k].bd;
      #1;
      check_rdy("vec_rdy", {a_ready, b_ready}, vecs[k].rdy);
      tick();
      #1;
      check_out("vec_out", out_v, vecs[k].out);
    end
    a_valid = 1'b0; b_valid = 1'b0;

    // Clear beats a simultaneous A request; a mid-sweep clear pulse is ignored.
    clear_req = 1'b1;
    a_valid = 1'b1; a_row = 3'd3; a_col = 3'd6; a_data = 9'd77;
    #1;
    check_rdy("clear_vs_a_rdy", {a_ready, b_ready}, 2'b00);
    expect_sweep(20);
    check_rdy("a_at_done_rdy", {a_ready, b_ready}, 2'b10);
    tick();
    #1;
    check_out("a_after_clear", out_v, pack(1'b1, 1'b0, 1'b0, 3'd3, 3'd6, 9'd77));
    a_valid = 1'b0;

    // Reset in the middle of a sweep restarts it from cell (0,0).
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (30) tick();
    #1;
    check_out("cell30", out_v, pack(1'b1, 1'b1, 1'b0, 3'd3, 3'd6, INIT_VAL));
    reset = 1'b1;
    #1;
    check_out("reset_mid_sweep", out_v, 18'd0);
    check_rdy("reset_mid_rdy", {a_ready, b_ready}, 2'b00);
    tick();
    reset = 1'b0;
    expect_sweep(-1);

    // Both requesters valid from the first arbitration after reset.
    ai = 0; bi = 0;
    for (int k = 0; k < 4; k++) begin
      a_valid = (ai < 2); {a_row, a_col, a_data} = alt_a[ai % 2];
      b_valid = (bi < 2); {b_row, b_col, b_data} = alt_b[bi % 2];
      #1;
      check_rdy("alt_rdy", {a_ready, b_ready}, alt_rdy[k]);
      tick();
      #1;
      check_out("alt_out", out_v, alt_out[k]);
      if (alt_rdy[k][1]) ai++;
      if (alt_rdy[k][0]) bi++;
    end
    a_valid = 1'b0; b_valid = 1'b0;

    // Randomized traffic against the reference model.
    m_sweep = 1'b0; m_last = 1'b1; m_hold = alt_b[1];
    for (int n = 0; n < 600; n++) begin
      if (!a_valid && $urandom_range(0, 2) != 0) begin
        a_valid = 1'b1;
        a_row = 3'($urandom_range(0, 7)); a_col = 3'($urandom_range(0, 7));
        a_data = 9'($urandom_range(0, 511));
      end
      if (!b_valid && $urandom_range(0, 2) != 0) begin
        b_valid = 1'b1;
        b_row = 3'($urandom_range(0, 7)); b_col = 3'($urandom_range(0, 7));
        b_data = 9'($urandom_range(0, 511));
      end
      clear_req = ($urandom_range(0, 59) == 0);
      #1;
      ma = !m_sweep && !clear_req && a_valid && (!b_valid || m_last);
      mb = !m_sweep && !clear_req && b_valid && (!a_valid || !m_last);
      check_rdy("rnd_rdy", {a_ready, b_ready}, {ma, mb});
      if (m_sweep) begin
        if (exp_q.size() > 0) begin
          m_hold = exp_q.pop_front();
          e_out = {3'b110, m_hold};
        end else begin
          m_sweep = 1'b0;
          e_out = {3'b001, m_hold};
        end
      end else if (clear_req) begin
        for (int c = 0; c < CELLS; c++) exp_q.push_back({3'(c / 8), 3'(c % 8), INIT_VAL});
        m_hold = exp_q.pop_front();
        m_sweep = 1'b1;
        e_out = {3'b110, m_hold};
      end else if (ma) begin
        m_hold = {a_row, a_col, a_data};
        m_last = 1'b0;
        e_out = {3'b100, m_hold};
      end else if (mb) begin
        m_hold = {b_row, b_col, b_data};
        m_last = 1'b1;
        e_out = {3'b100, m_hold};
      end else begin
        e_out = {3'b000, m_hold};
      end
      tick();
      check_out("rnd_out", out_v, e_out);
      if (ma) a_valid = 1'b0;
      if (mb) b_valid = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
